// File: rtl/divider_seq_ctrl_if.sv
// Request/response bundle between the execute stage, the divider sequencer and writeback.
interface divider_seq_ctrl_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [1:0]  i_op;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic [4:0]  i_tag;
  logic        i_flush;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  logic        o_busy;

  modport master (
    output i_req_valid, i_op, i_dividend, i_divisor, i_tag, i_flush, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_result, o_tag, o_busy
  );

  modport slave (
    input  i_req_valid, i_op, i_dividend, i_divisor, i_tag, i_flush, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_result, o_tag, o_busy
  );
endinterface

// File: rtl/divider_seq_ctrl.sv
// Multi-cycle restoring divider sequencer for RV32M DIV/DIVU/REM/REMU with tagged results.
// ITERS_PER_CYC restoring steps run per clock; special cases bypass the iteration.
module divider_seq_ctrl #(
  parameter int unsigned ITERS_PER_CYC = 1
) (
  input logic               clk,
  input logic               rst,
  divider_seq_ctrl_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 5;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] STEP = CW'(ITERS_PER_CYC);
  localparam logic [CW-1:0] LAST = CW'(DW);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] MIN_INT = 32'h8000_0000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] rem_q, rem_d, quo_q, quo_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic [1:0]    op_q, op_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [DW-1:0] result_q, result_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          ready_q, busy_q;

  logic [DW-1:0] calc_rem, calc_quo, calc_dvd, shifted;
  logic          sa, sb, div_zero, ovf;
  logic [DW-1:0] mag_a, mag_b, spec_res, res_mag;
  logic          res_neg;

  // Unrolled restoring steps for one clock.
  always_comb begin
    calc_rem = rem_q;
    calc_quo = quo_q;
    calc_dvd = dvd_q;
    shifted  = '0;
    for (int unsigned i = 0; i < ITERS_PER_CYC; i++) begin
      shifted = {calc_rem[DW-2:0], calc_dvd[DW-1]};
      if (shifted >= dvs_q) begin
        calc_rem = shifted - dvs_q;
        calc_quo = {calc_quo[DW-2:0], 1'b1};
      end else begin
        calc_rem = shifted;
        calc_quo = {calc_quo[DW-2:0], 1'b0};
      end
      calc_dvd = {calc_dvd[DW-2:0], 1'b0};
    end
  end

  // Operand conditioning and special-case decode at capture.
  always_comb begin
    sa       = ~bus.i_op[0] & bus.i_dividend[DW-1];
    sb       = ~bus.i_op[0] & bus.i_divisor[DW-1];
    mag_a    = sa ? (~bus.i_dividend + ONE) : bus.i_dividend;
    mag_b    = sb ? (~bus.i_divisor + ONE) : bus.i_divisor;
    div_zero = (bus.i_divisor == '0);
    ovf      = ~bus.i_op[0] & (bus.i_dividend == MIN_INT) & (bus.i_divisor == '1);
    spec_res = '0;
    if (div_zero) spec_res = bus.i_op[1] ? bus.i_dividend : '1;
    else if (ovf) spec_res = bus.i_op[1] ? '0 : MIN_INT;
    res_mag  = op_q[1] ? calc_rem : calc_quo;
    res_neg  = op_q[1] ? neg_r_q : neg_q_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    op_d        = op_q;
    tag_d       = tag_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.i_req_valid && !bus.i_flush) begin
          op_d    = bus.i_op;
          tag_d   = bus.i_tag;
          neg_q_d = sa ^ sb;
          neg_r_d = sa;
          rem_d   = '0;
          quo_d   = '0;
          dvd_d   = mag_a;
          dvs_d   = mag_b;
          count_d = '0;
          if (div_zero || ovf) begin
            state_d     = DONE;
            result_d    = spec_res;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d   = calc_rem;
        quo_d   = calc_quo;
        dvd_d   = calc_dvd;
        count_d = count_q + STEP;
        if (count_d == LAST) begin
          state_d     = DONE;
          result_d    = res_neg ? (~res_mag + ONE) : res_mag;
          rsp_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush kills everything, including a response the consumer may be taking.
    if (bus.i_flush) begin
      state_d     = IDLE;
      count_d     = '0;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_result    = result_q;
  assign bus.o_tag       = tag_q;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Scoreboard bench for divider_seq_ctrl; runs the same suite on a 1-iteration and a 4-iteration build.
module tb_divider_seq_ctrl;

  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_tag = '0;

  logic        rsp_valid, req_ready, busy;
  logic [31:0] result;
  logic [4:0]  rsp_tag;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  divider_seq_ctrl_if bus1 ();
  divider_seq_ctrl_if bus4 ();

  divider_seq_ctrl #(.ITERS_PER_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  divider_seq_ctrl #(.ITERS_PER_CYC(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus1.i_req_valid = req_valid & ~sel;
  assign bus4.i_req_valid = req_valid & sel;
  assign bus1.i_flush     = flush & ~sel;
  assign bus4.i_flush     = flush & sel;
  assign bus1.i_op = req_op;       assign bus4.i_op = req_op;
  assign bus1.i_dividend = req_a;  assign bus4.i_dividend = req_a;
  assign bus1.i_divisor = req_b;   assign bus4.i_divisor = req_b;
  assign bus1.i_tag = req_tag;     assign bus4.i_tag = req_tag;
  assign bus1.i_rsp_ready = rsp_ready;
  assign bus4.i_rsp_ready = rsp_ready;

  assign rsp_valid = sel ? bus4.o_rsp_valid : bus1.o_rsp_valid;
  assign req_ready = sel ? bus4.o_req_ready : bus1.o_req_ready;
  assign busy      = sel ? bus4.o_busy      : bus1.o_busy;
  assign result    = sel ? bus4.o_result    : bus1.o_result;
  assign rsp_tag   = sel ? bus4.o_tag       : bus1.o_tag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (iters=%0d): got %h, expected %h", name, sel ? 4 : 1, got, exp);
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      OP_DIV:  return 32'($signed(a) / $signed(b));
      OP_DIVU: return a / b;
      OP_REM:  return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Present one request at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    check("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = o; req_a = a; req_b = b; req_tag = t;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_a = $urandom; req_b = $urandom; req_tag = 5'($urandom);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] res, input bit special);
    exp_t e;
    e.res = res;
    e.tag = t;
    e.lat = special ? 1 : 1 + 32 / (sel ? 4 : 1);
    sb.push_back(e);
    send(o, a, b, t);
  endtask

  task automatic expect_rsp(input int unsigned hold);
    exp_t        e;
    int unsigned n;
    n = 0;
    rsp_ready = (hold == 0);
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("latency", n + 1, e.lat);
    check("result", result, e.res);
    check("tag", 32'(rsp_tag), 32'(e.tag));
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_result", result, e.res);
      check("hold_tag", 32'(rsp_tag), 32'(e.tag));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run_suite();
    logic [1:0]  o;
    logic [31:0] a, b;
    bit          seen;

    issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 0);                  expect_rsp(0);
    issue(OP_REMU, 32'd100, 32'd7, 5'd3, 32'd2, 0);                   expect_rsp(0);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 0);     expect_rsp(0);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0);     expect_rsp(0);
    issue(OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 0);     expect_rsp(0);
    issue(OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, 0);             expect_rsp(0);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'hFFFF_FFFF, 0);     expect_rsp(0);
    issue(OP_DIV,  32'h8000_0000, 32'd2, 5'd10, 32'hC000_0000, 0);    expect_rsp(0);
    issue(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd11, 32'd1, 0);    expect_rsp(0);
    // Special cases complete in one cycle.
    issue(OP_DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);            expect_rsp(0);
    issue(OP_REM,  32'd5, 32'd0, 5'd13, 32'd5, 1);                    expect_rsp(0);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);    expect_rsp(0);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFF9, 1);    expect_rsp(0);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1); expect_rsp(0);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1);    expect_rsp(0);

    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom >> $urandom_range(0, 31)) | 32'd1;
      issue(o, a, b, 5'(i + 20), ref_div(o, a, b), 0);
      expect_rsp(0);
    end

    // Back-pressure for 10 cycles in DONE.
    rsp_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 0);
    expect_rsp(10);

    // Flush halfway through CALC, then a full-latency operation.
    send(OP_DIVU, 32'd1000, 32'd3, 5'd30);
    repeat (16 / (sel ? 4 : 1)) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) seen = 1;
      @(negedge clk);
    end
    check("flush_no_rsp", 32'(seen), 32'd0);
    issue(OP_DIVU, 32'd9, 32'd3, 5'd2, 32'd3, 0);
    expect_rsp(0);

    // A request coinciding with flush is dropped.
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd5; req_b = 32'd0; req_tag = 5'd1;
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req_busy", 32'(busy), 32'd0);
    check("flush_req_valid", 32'(rsp_valid), 32'd0);

    // Asynchronous reset mid-CALC.
    send(OP_DIVU, 32'd100, 32'd7, 5'd9);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_tag", 32'(rsp_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_ready", 32'(req_ready), 32'd1);
    issue(OP_DIVU, 32'd20, 32'd4, 5'd4, 32'd5, 0);
    expect_rsp(0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("reset_valid", 32'(rsp_valid), 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_tag", 32'(rsp_tag), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    run_suite();
    sel = 1'b1;
    @(negedge clk);
    run_suite();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
